// File: rtl/vga_multimode.sv
// ----------------------------------------------------------------------------
// vga_multimode
//
// Purpose:
//   VGA timing generator with two selectable video modes. Free-running
//   horizontal/vertical counters drive a request stage that asks an external
//   pixel source for (px_x, px_y). The source answers PIXEL_LATENCY cycles
//   later. A delay line carries de/sync/mode alongside each request so that
//   the registered VGA outputs line up with the returned pixel data. The
//   mode only changes at a frame boundary, so a frame is never torn.
//
// Ports:
//   clk                   pixel clock
//   rst_n                 synchronous active-low reset
//   en                    timing enable; the counters hold while low
//   mode_sel              requested mode, taken at the last pixel of a frame
//   pixel_r/g/b           pixel data from the source (COLOR_W bits each)
//   req_valid             pixel request strobe
//   px_x, px_y            requested pixel coordinates (0 when no request)
//   frame_start           request-stage pulse at counter position (0,0)
//   line_start            request-stage pulse at hcnt = 0
//   cur_mode              mode the counters are currently running
//   vga_hsync, vga_vsync  sync outputs with per-mode polarity
//   vga_de                display enable
//   vga_r/g/b             colour outputs, forced to 0 outside the active area
//
// Timing parameters are packed as {active, front porch, sync, back porch},
// 12 bits per field. POL is {hsync, vsync}, where 1 means active-high.
// ----------------------------------------------------------------------------
module vga_multimode #(
    parameter int          COLOR_W       = 4,
    parameter int          PIXEL_LATENCY = 2,
    parameter logic [47:0] M0_H          = {12'd800, 12'd24, 12'd72, 12'd128},
    parameter logic [47:0] M0_V          = {12'd600, 12'd1, 12'd2, 12'd22},
    parameter logic [1:0]  M0_POL        = 2'b11,
    parameter logic [47:0] M1_H          = {12'd640, 12'd56, 12'd56, 12'd80},
    parameter logic [47:0] M1_V          = {12'd480, 12'd1, 12'd3, 12'd25},
    parameter logic [1:0]  M1_POL        = 2'b00
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode_sel,
    input  logic [COLOR_W-1:0] pixel_r,
    input  logic [COLOR_W-1:0] pixel_g,
    input  logic [COLOR_W-1:0] pixel_b,
    output logic               req_valid,
    output logic [11:0]        px_x,
    output logic [11:0]        px_y,
    output logic               frame_start,
    output logic               line_start,
    output logic               cur_mode,
    output logic               vga_hsync,
    output logic               vga_vsync,
    output logic               vga_de,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b
);

    // Derived per-mode boundaries. The sync window is [SS, SE).
    // MAX is the last counter value before the counter wraps.
    localparam logic [11:0] M0_HACT = M0_H[47:36];
    localparam logic [11:0] M0_HSS  = M0_H[47:36] + M0_H[35:24];
    localparam logic [11:0] M0_HSE  = M0_HSS + M0_H[23:12];
    localparam logic [11:0] M0_HMAX = M0_HSE + M0_H[11:0] - 12'd1;
    localparam logic [11:0] M0_VACT = M0_V[47:36];
    localparam logic [11:0] M0_VSS  = M0_V[47:36] + M0_V[35:24];
    localparam logic [11:0] M0_VSE  = M0_VSS + M0_V[23:12];
    localparam logic [11:0] M0_VMAX = M0_VSE + M0_V[11:0] - 12'd1;

    localparam logic [11:0] M1_HACT = M1_H[47:36];
    localparam logic [11:0] M1_HSS  = M1_H[47:36] + M1_H[35:24];
    localparam logic [11:0] M1_HSE  = M1_HSS + M1_H[23:12];
    localparam logic [11:0] M1_HMAX = M1_HSE + M1_H[11:0] - 12'd1;
    localparam logic [11:0] M1_VACT = M1_V[47:36];
    localparam logic [11:0] M1_VSS  = M1_V[47:36] + M1_V[35:24];
    localparam logic [11:0] M1_VSE  = M1_VSS + M1_V[23:12];
    localparam logic [11:0] M1_VMAX = M1_VSE + M1_V[11:0] - 12'd1;

    // Per-request attributes that travel down the pixel-latency delay line.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic mode;
    } pipe_t;

    logic [11:0]  r_hcnt;
    logic [11:0]  r_vcnt;
    logic         r_curMode;

    logic         r_reqValid;
    logic [11:0]  r_pxX;
    logic [11:0]  r_pxY;
    logic         r_frameStart;
    logic         r_lineStart;
    logic         r_reqHs;
    logic         r_reqVs;
    logic         r_reqMode;

    pipe_t        r_pipe [PIXEL_LATENCY];

    logic               r_de;
    logic               r_hsync;
    logic               r_vsync;
    logic [COLOR_W-1:0] r_red;
    logic [COLOR_W-1:0] r_green;
    logic [COLOR_W-1:0] r_blue;

    logic [11:0]  w_hAct;
    logic [11:0]  w_hSyncStart;
    logic [11:0]  w_hSyncEnd;
    logic [11:0]  w_hMax;
    logic [11:0]  w_vAct;
    logic [11:0]  w_vSyncStart;
    logic [11:0]  w_vSyncEnd;
    logic [11:0]  w_vMax;
    logic         w_hLast;
    logic         w_vLast;
    logic         w_active;
    logic         w_hsActive;
    logic         w_vsActive;
    pipe_t        w_tail;
    logic         w_polH;
    logic         w_polV;

    // Select the timing of the mode the counters are currently running.
    always_comb begin
        w_hAct       = M0_HACT;
        w_hSyncStart = M0_HSS;
        w_hSyncEnd   = M0_HSE;
        w_hMax       = M0_HMAX;
        w_vAct       = M0_VACT;
        w_vSyncStart = M0_VSS;
        w_vSyncEnd   = M0_VSE;
        w_vMax       = M0_VMAX;
        if (r_curMode) begin
            w_hAct       = M1_HACT;
            w_hSyncStart = M1_HSS;
            w_hSyncEnd   = M1_HSE;
            w_hMax       = M1_HMAX;
            w_vAct       = M1_VACT;
            w_vSyncStart = M1_VSS;
            w_vSyncEnd   = M1_VSE;
            w_vMax       = M1_VMAX;
        end
    end

    // All request-stage terms are qualified by en, so a stalled counter
    // produces no request, no pulses and inactive syncs.
    always_comb begin
        w_hLast    = (r_hcnt == w_hMax);
        w_vLast    = (r_vcnt == w_vMax);
        w_active   = en && (r_hcnt < w_hAct) && (r_vcnt < w_vAct);
        w_hsActive = en && (r_hcnt >= w_hSyncStart) && (r_hcnt < w_hSyncEnd);
        w_vsActive = en && (r_vcnt >= w_vSyncStart) && (r_vcnt < w_vSyncEnd);
    end

    // Position counters. mode_sel is taken only on the last pixel of a
    // frame, so the next frame starts at (0,0) under the new timing and a
    // mode change can never split a frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hcnt    <= 12'd0;
            r_vcnt    <= 12'd0;
            r_curMode <= 1'b0;
        end else if (en) begin
            if (w_hLast) begin
                r_hcnt <= 12'd0;
                if (w_vLast) begin
                    r_vcnt    <= 12'd0;
                    r_curMode <= mode_sel;
                end else begin
                    r_vcnt <= r_vcnt + 12'd1;
                end
            end else begin
                r_hcnt <= r_hcnt + 12'd1;
            end
        end
    end

    // Request stage, one cycle behind the counters. The mode is captured
    // here as well, so the outputs keep the polarity of the frame this
    // pixel belongs to even after cur_mode has switched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_reqValid   <= 1'b0;
            r_pxX        <= 12'd0;
            r_pxY        <= 12'd0;
            r_frameStart <= 1'b0;
            r_lineStart  <= 1'b0;
            r_reqHs      <= 1'b0;
            r_reqVs      <= 1'b0;
            r_reqMode    <= 1'b0;
        end else begin
            r_reqValid   <= w_active;
            r_pxX        <= w_active ? r_hcnt : 12'd0;
            r_pxY        <= w_active ? r_vcnt : 12'd0;
            r_frameStart <= en && (r_hcnt == 12'd0) && (r_vcnt == 12'd0);
            r_lineStart  <= en && (r_hcnt == 12'd0);
            r_reqHs      <= w_hsActive;
            r_reqVs      <= w_vsActive;
            r_reqMode    <= r_curMode;
        end
    end

    // Delay line matching the pixel source latency. It runs regardless of
    // en, because the source always answers a fixed number of cycles after
    // each request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < PIXEL_LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= '{de: r_reqValid, hs: r_reqHs, vs: r_reqVs, mode: r_reqMode};
            for (int i = 1; i < PIXEL_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // The pipeline tail lines up with the pixel data on the inputs.
    always_comb begin
        w_tail = r_pipe[PIXEL_LATENCY-1];
        w_polH = w_tail.mode ? M1_POL[1] : M0_POL[1];
        w_polV = w_tail.mode ? M1_POL[0] : M0_POL[0];
    end

    // Output registers. The sync level is the active-high sync XOR ~POL,
    // so an inactive sync idles at ~POL. That is also the reset level for
    // mode 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_de    <= 1'b0;
            r_hsync <= ~M0_POL[1];
            r_vsync <= ~M0_POL[0];
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else begin
            r_de    <= w_tail.de;
            r_hsync <= w_tail.hs ^ ~w_polH;
            r_vsync <= w_tail.vs ^ ~w_polV;
            r_red   <= w_tail.de ? pixel_r : '0;
            r_green <= w_tail.de ? pixel_g : '0;
            r_blue  <= w_tail.de ? pixel_b : '0;
        end
    end

    assign req_valid   = r_reqValid;
    assign px_x        = r_pxX;
    assign px_y        = r_pxY;
    assign frame_start = r_frameStart;
    assign line_start  = r_lineStart;
    assign cur_mode    = r_curMode;
    assign vga_hsync   = r_hsync;
    assign vga_vsync   = r_vsync;
    assign vga_de      = r_de;
    assign vga_r       = r_red;
    assign vga_g       = r_green;
    assign vga_b       = r_blue;

endmodule

// File: tb/tb_vga_multimode.sv
// ----------------------------------------------------------------------------
// tb_vga_multimode
//
// Purpose:
//   Directed testbench for vga_multimode. It uses shrunken video modes so
//   that whole frames fit in a few hundred cycles.
//     mode 0: H {8,2,3,3}  -> 16 clocks/line, hsync active-high on h 10..12
//             V {4,1,2,1}  ->  8 lines/frame, vsync active-high on v 5..6
//     mode 1: H {6,1,2,3}  -> 12 clocks/line, hsync active-low  on h 7..8
//             V {3,1,1,2}  ->  7 lines/frame, vsync active-low  on v 4
//   PIXEL_LATENCY = 2.
//
//   Edge numbering: E1 is the first rising edge with rst_n high. After edge
//   En, the request stage shows counter position n-1 and the VGA outputs
//   show position n-4.
//
//   The pixel source drives a value derived from the edge number.
//   vga_r/g/b after En must therefore equal the value that was driven
//   after E(n-1).
// ----------------------------------------------------------------------------
module tb_vga_multimode;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        mode_sel;
    logic [3:0]  pixel_r;
    logic [3:0]  pixel_g;
    logic [3:0]  pixel_b;
    logic        req_valid;
    logic [11:0] px_x;
    logic [11:0] px_y;
    logic        frame_start;
    logic        line_start;
    logic        cur_mode;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_de;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;

    int cyc;
    int checks;
    int errors;

    // One expected snapshot, taken right after edge n.
    typedef struct {
        int          n;
        logic        rv;
        logic [11:0] px;
        logic [11:0] py;
        logic        fs;
        logic        ls;
        logic        de;
        logic        hs;
        logic        vs;
    } vec_t;

    vec_t vecs[$];

    vga_multimode #(
        .COLOR_W       (4),
        .PIXEL_LATENCY (2),
        .M0_H          ({12'd8, 12'd2, 12'd3, 12'd3}),
        .M0_V          ({12'd4, 12'd1, 12'd2, 12'd1}),
        .M0_POL        (2'b11),
        .M1_H          ({12'd6, 12'd1, 12'd2, 12'd3}),
        .M1_V          ({12'd3, 12'd1, 12'd1, 12'd2}),
        .M1_POL        (2'b00)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .mode_sel    (mode_sel),
        .pixel_r     (pixel_r),
        .pixel_g     (pixel_g),
        .pixel_b     (pixel_b),
        .req_valid   (req_valid),
        .px_x        (px_x),
        .px_y        (px_y),
        .frame_start (frame_start),
        .line_start  (line_start),
        .cur_mode    (cur_mode),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .vga_de      (vga_de),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Deterministic pixel pattern. Red is never zero and green is all ones.
    function automatic logic [3:0] pixR(input int m);
        return 4'((m % 15) + 1);
    endfunction

    function automatic logic [3:0] pixB(input int m);
        return 4'(m % 16);
    endfunction

    task automatic drivePixels();
        pixel_r = pixR(cyc);
        pixel_g = 4'hF;
        pixel_b = pixB(cyc);
    endtask

    // Advance one clock, then drive the pixel data for that cycle.
    // Outputs are sampled 1 time unit after the rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        cyc++;
        drivePixels();
    endtask

    task automatic stepTo(input int n);
        while (cyc < n) applyStimulus();
    endtask

    task automatic checkOutput(input string name, input logic [11:0] act,
                               input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d",
                     name, cyc, act, exp);
        end
    endtask

    task automatic checkRgb(input logic de);
        checkOutput("vga_r", 12'(vga_r), de ? 12'(pixR(cyc - 1)) : 12'd0);
        checkOutput("vga_g", 12'(vga_g), de ? 12'hF : 12'd0);
        checkOutput("vga_b", 12'(vga_b), de ? 12'(pixB(cyc - 1)) : 12'd0);
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        applyStimulus();
        applyStimulus();
    endtask

    task automatic releaseReset();
        rst_n = 1'b1;
        cyc   = 0;
        drivePixels();
    endtask

    task automatic addVec(input int n, input logic rv, input int px,
                          input int py, input logic fs, input logic ls,
                          input logic de, input logic hs, input logic vs);
        vec_t v;
        v.n  = n;
        v.rv = rv;
        v.px = 12'(px);
        v.py = 12'(py);
        v.fs = fs;
        v.ls = ls;
        v.de = de;
        v.hs = hs;
        v.vs = vs;
        vecs.push_back(v);
    endtask

    // Safety net so that the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected normal finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int deCnt;
        int hsCnt;
        int vsCnt;
        int rgbStray;

        checks   = 0;
        errors   = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        en       = 1'b1;
        mode_sel = 1'b0;
        drivePixels();

        // Mode-0 checkpoints, derived by hand from the shrunken timing.
        //     n   rv px py fs ls de hs vs
        addVec(1,   1, 0, 0, 1, 1, 0, 0, 0);
        addVec(2,   1, 1, 0, 0, 0, 0, 0, 0);
        addVec(3,   1, 2, 0, 0, 0, 0, 0, 0);
        addVec(4,   1, 3, 0, 0, 0, 1, 0, 0);
        addVec(9,   0, 0, 0, 0, 0, 1, 0, 0);
        addVec(12,  0, 0, 0, 0, 0, 0, 0, 0);
        addVec(14,  0, 0, 0, 0, 0, 0, 1, 0);
        addVec(16,  0, 0, 0, 0, 0, 0, 1, 0);
        addVec(17,  1, 0, 1, 0, 1, 0, 0, 0);
        addVec(20,  1, 3, 1, 0, 0, 1, 0, 0);
        addVec(56,  1, 7, 3, 0, 0, 1, 0, 0);
        addVec(65,  0, 0, 0, 0, 1, 0, 0, 0);
        addVec(84,  0, 0, 0, 0, 0, 0, 0, 1);
        addVec(94,  0, 0, 0, 0, 0, 0, 1, 1);
        addVec(116, 0, 0, 0, 0, 0, 0, 0, 0);
        addVec(129, 1, 0, 0, 1, 1, 0, 0, 0);
        addVec(132, 1, 3, 0, 0, 0, 1, 0, 0);

        // ---------------- reset state ----------------
        resetDut();
        checkOutput("rst req_valid", 12'(req_valid), 12'd0);
        checkOutput("rst px_x", px_x, 12'd0);
        checkOutput("rst px_y", px_y, 12'd0);
        checkOutput("rst frame_start", 12'(frame_start), 12'd0);
        checkOutput("rst line_start", 12'(line_start), 12'd0);
        checkOutput("rst cur_mode", 12'(cur_mode), 12'd0);
        checkOutput("rst vga_de", 12'(vga_de), 12'd0);
        checkOutput("rst hsync", 12'(vga_hsync), 12'd0);
        checkOutput("rst vsync", 12'(vga_vsync), 12'd0);
        checkRgb(1'b0);
        releaseReset();

        // ---------------- mode-0 vector table ----------------
        foreach (vecs[i]) begin
            stepTo(vecs[i].n);
            checkOutput("req_valid", 12'(req_valid), 12'(vecs[i].rv));
            checkOutput("px_x", px_x, vecs[i].px);
            checkOutput("px_y", px_y, vecs[i].py);
            checkOutput("frame_start", 12'(frame_start), 12'(vecs[i].fs));
            checkOutput("line_start", 12'(line_start), 12'(vecs[i].ls));
            checkOutput("vga_de", 12'(vga_de), 12'(vecs[i].de));
            checkOutput("vga_hsync", 12'(vga_hsync), 12'(vecs[i].hs));
            checkOutput("vga_vsync", 12'(vga_vsync), 12'(vecs[i].vs));
            checkOutput("cur_mode", 12'(cur_mode), 12'd0);
            checkRgb(vecs[i].de);
        end

        // One full mode-0 frame: 8x4 de cycles, 3x8 hsync cycles,
        // 2x16 vsync cycles, and no colour outside de.
        deCnt = 0; hsCnt = 0; vsCnt = 0; rgbStray = 0;
        for (int k = 0; k < 128; k++) begin
            applyStimulus();
            if (vga_de) deCnt++;
            if (vga_hsync) hsCnt++;
            if (vga_vsync) vsCnt++;
            if (!vga_de && (vga_r != 4'd0 || vga_g != 4'd0 || vga_b != 4'd0)) rgbStray++;
        end
        checkOutput("m0 de count", 12'(deCnt), 12'd32);
        checkOutput("m0 hsync high count", 12'(hsCnt), 12'd24);
        checkOutput("m0 vsync high count", 12'(vsCnt), 12'd32);
        checkOutput("m0 rgb outside de", 12'(rgbStray), 12'd0);

        // ---------------- mode switch at frame end ----------------
        mode_sel = 1'b1;
        resetDut();
        releaseReset();
        stepTo(127);
        checkOutput("sw cur_mode before", 12'(cur_mode), 12'd0);
        stepTo(128);
        checkOutput("sw cur_mode after", 12'(cur_mode), 12'd1);
        stepTo(129);
        checkOutput("sw frame_start", 12'(frame_start), 12'd1);
        checkOutput("sw req_valid", 12'(req_valid), 12'd1);
        stepTo(131);
        checkOutput("sw last m0 hsync", 12'(vga_hsync), 12'd0);
        checkOutput("sw last m0 vsync", 12'(vga_vsync), 12'd0);
        checkOutput("sw last m0 de", 12'(vga_de), 12'd0);
        stepTo(132);
        checkOutput("sw first m1 de", 12'(vga_de), 12'd1);
        checkOutput("sw first m1 hsync", 12'(vga_hsync), 12'd1);
        checkOutput("sw first m1 vsync", 12'(vga_vsync), 12'd1);
        checkRgb(1'b1);

        // One full mode-1 frame: hsync low 2 of every 12 clocks across
        // 7 lines, vsync low for 1 line, and 6x3 de cycles.
        deCnt = 0; hsCnt = 0; vsCnt = 0;
        for (int k = 0; k < 84; k++) begin
            applyStimulus();
            if (vga_de) deCnt++;
            if (!vga_hsync) hsCnt++;
            if (!vga_vsync) vsCnt++;
        end
        checkOutput("m1 de count", 12'(deCnt), 12'd18);
        checkOutput("m1 hsync low count", 12'(hsCnt), 12'd14);
        checkOutput("m1 vsync low count", 12'(vsCnt), 12'd12);
        checkOutput("m1 cur_mode", 12'(cur_mode), 12'd1);

        // ---------------- reset during mode-1 vsync ----------------
        stepTo(266);
        checkOutput("vs line vsync", 12'(vga_vsync), 12'd0);
        checkOutput("vs line hsync", 12'(vga_hsync), 12'd1);
        rst_n = 1'b0;
        applyStimulus();
        checkOutput("midrst cur_mode", 12'(cur_mode), 12'd0);
        checkOutput("midrst hsync", 12'(vga_hsync), 12'd0);
        checkOutput("midrst vsync", 12'(vga_vsync), 12'd0);
        checkOutput("midrst de", 12'(vga_de), 12'd0);
        checkOutput("midrst req_valid", 12'(req_valid), 12'd0);
        checkOutput("midrst px_x", px_x, 12'd0);
        checkOutput("midrst px_y", px_y, 12'd0);
        checkOutput("midrst line_start", 12'(line_start), 12'd0);
        checkRgb(1'b0);
        releaseReset();
        stepTo(5);
        checkOutput("post rst cur_mode", 12'(cur_mode), 12'd0);

        // ---------------- mid-frame mode_sel toggle ----------------
        mode_sel = 1'b0;
        resetDut();
        releaseReset();
        stepTo(30);
        mode_sel = 1'b1;
        stepTo(60);
        mode_sel = 1'b0;
        stepTo(100);
        checkOutput("toggle cur_mode mid", 12'(cur_mode), 12'd0);
        stepTo(129);
        checkOutput("toggle cur_mode end", 12'(cur_mode), 12'd0);
        checkOutput("toggle frame_start", 12'(frame_start), 12'd1);

        // ---------------- en stall mid active line ----------------
        resetDut();
        releaseReset();
        stepTo(5);
        en = 1'b0;
        stepTo(8);
        checkOutput("stall de before", 12'(vga_de), 12'd1);
        checkRgb(1'b1);
        stepTo(9);
        checkOutput("stall de first", 12'(vga_de), 12'd0);
        checkOutput("stall req_valid", 12'(req_valid), 12'd0);
        checkRgb(1'b0);
        stepTo(15);
        checkOutput("stall req_valid end", 12'(req_valid), 12'd0);
        checkOutput("stall px_x", px_x, 12'd0);
        en = 1'b1;
        stepTo(16);
        checkOutput("resume req_valid", 12'(req_valid), 12'd1);
        checkOutput("resume px_x", px_x, 12'd5);
        stepTo(17);
        checkOutput("resume px_x next", px_x, 12'd6);
        stepTo(18);
        checkOutput("stall de last", 12'(vga_de), 12'd0);
        checkRgb(1'b0);
        stepTo(19);
        checkOutput("resume de", 12'(vga_de), 12'd1);
        checkRgb(1'b1);
        stepTo(26);
        checkOutput("long line no ls", 12'(line_start), 12'd0);
        stepTo(27);
        checkOutput("long line ls", 12'(line_start), 12'd1);
        checkOutput("long line px_y", px_y, 12'd1);
        checkOutput("long line px_x", px_x, 12'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
